// File: rtl/demux_ser_driver.sv
// -----------------------------------------------------------------------------
// demux_ser_driver
//
// Upstream feeder for a 1-to-N single-bit demultiplexer. A parallel word and a
// destination channel are taken over a valid/ready handshake. The channel is
// held on `sel` while the word is shifted MSB-first onto `demux_in`, one bit
// per clock, followed by GAP idle cycles. Outside of SHIFT, `demux_in` is
// forced low, so every demux output is 0 while nothing is being sent.
//
// Ports:
//   clk       in   single clock, rising-edge
//   rst       in   synchronous, active-high reset
//   in_valid  in   request present
//   in_ready  out  request can be accepted this cycle (state == IDLE)
//   in_data   in   DATA_W-bit word to serialise
//   in_chan   in   SEL_W-bit destination channel
//   demux_in  out  serial bit to the demux data input
//   sel       out  channel select to the demux, stable for a whole frame
//   busy      out  high in SHIFT or GAP
//   done      out  one-cycle pulse in the cycle after the last bit
//
// All outputs come from registers or are decoded from registered state only.
// -----------------------------------------------------------------------------
module demux_ser_driver #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_chan,
  output logic              demux_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done
);

  // Counters are kept at least 1 bit wide so DATA_W = 1 / GAP <= 1 still elaborate.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shreg;
  logic [DATA_W-1:0]  w_shreg_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_done;
  logic               w_done_nxt;

  // Next-state and datapath decode; every register holds unless its state says otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sel_nxt     = r_sel;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone is the accept.
        if (in_valid) begin
          w_state_nxt   = S_SHIFT;
          w_shreg_nxt   = in_data;
          w_sel_nxt     = in_chan;
          w_bit_cnt_nxt = CNT_W'(DATA_W - 1);
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = r_shreg << 1;
        if (r_bit_cnt == '0) begin
          // Last bit has now been on the line for a full cycle.
          w_done_nxt = 1'b1;
          if (GAP > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt   = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sel     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Gating with SHIFT keeps the line low in IDLE/GAP regardless of shreg contents.
  assign demux_in = (r_state == S_SHIFT) & r_shreg[DATA_W-1];
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign sel      = r_sel;
  assign done     = r_done;

endmodule

// File: tb/tb_demux_ser_driver.sv
// -----------------------------------------------------------------------------
// tb_demux_ser_driver
//
// Directed bench for demux_ser_driver. Three instances share clk/rst:
//   u_dut   DATA_W=8, GAP=1 (default)
//   u_dut4  DATA_W=4, GAP=0
//   u_dutg  DATA_W=8, GAP=3
// A 1-to-8 demux is modelled on the default instance for the integration step.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_demux_ser_driver;

  logic       clk;
  logic       rst;

  logic       v8, rdy8, din8, busy8, done8;
  logic [7:0] d8;
  logic [2:0] c8, sel8;

  logic       v4, rdy4, din4, busy4, done4;
  logic [3:0] d4;
  logic [2:0] c4, sel4;

  logic       vg, rdyg, ding, busyg, doneg;
  logic [7:0] dg;
  logic [2:0] cg, selg;

  logic [7:0] dmx;

  int checks   = 0;
  int failures = 0;

  demux_ser_driver #(.DATA_W(8), .SEL_W(3), .GAP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_chan(c8), .demux_in(din8), .sel(sel8), .busy(busy8), .done(done8)
  );

  demux_ser_driver #(.DATA_W(4), .SEL_W(3), .GAP(0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_chan(c4), .demux_in(din4), .sel(sel4), .busy(busy4), .done(done4)
  );

  demux_ser_driver #(.DATA_W(8), .SEL_W(3), .GAP(3)) u_dutg (
    .clk(clk), .rst(rst), .in_valid(vg), .in_ready(rdyg), .in_data(dg),
    .in_chan(cg), .demux_in(ding), .sel(selg), .busy(busyg), .done(doneg)
  );

  // 1-to-8 demux fed by the default instance
  always_comb begin
    dmx = 8'h00;
    if (din8) dmx = 8'h01 << sel8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks cycles 1..10 after an accept on u_dut (8 SHIFT, 1 GAP, then IDLE).
  // Entered in cycle 1; leaves in cycle 10 without advancing the clock.
  task automatic frame8(input string t, input logic [7:0] d, input logic [2:0] ch);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("%s_bit%0d", t, k),  {31'd0, din8},  {31'd0, d[8-k]});
      check($sformatf("%s_sel%0d", t, k),  {29'd0, sel8},  {29'd0, ch});
      check($sformatf("%s_busy%0d", t, k), {31'd0, busy8}, 32'd1);
      check($sformatf("%s_rdy%0d", t, k),  {31'd0, rdy8},  32'd0);
      check($sformatf("%s_done%0d", t, k), {31'd0, done8}, 32'd0);
      tick();
    end
    check({t, "_gap_din"},  {31'd0, din8},  32'd0);
    check({t, "_gap_sel"},  {29'd0, sel8},  {29'd0, ch});
    check({t, "_gap_busy"}, {31'd0, busy8}, 32'd1);
    check({t, "_gap_done"}, {31'd0, done8}, 32'd1);
    check({t, "_gap_rdy"},  {31'd0, rdy8},  32'd0);
    tick();
    check({t, "_idle_rdy"},  {31'd0, rdy8},  32'd1);
    check({t, "_idle_busy"}, {31'd0, busy8}, 32'd0);
    check({t, "_idle_done"}, {31'd0, done8}, 32'd0);
    check({t, "_idle_din"},  {31'd0, din8},  32'd0);
    check({t, "_idle_sel"},  {29'd0, sel8},  {29'd0, ch});
  endtask

  initial begin
    logic [7:0] exp_dmx;
    logic [7:0] one_hot;
    logic [3:0] pat4;
    logic [7:0] patg;

    rst = 1'b1;
    v8 = 1'b0; d8 = 8'h00; c8 = 3'd0;
    v4 = 1'b0; d4 = 4'h0;  c4 = 3'd0;
    vg = 1'b0; dg = 8'h00; cg = 3'd0;

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_rdy",  {31'd0, rdy8},  32'd1);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_din",  {31'd0, din8},  32'd0);
    check("rst_sel",  {29'd0, sel8},  32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_dmx",  {24'd0, dmx},   32'd0);

    // 1. Single frame 0xA5 on channel 3
    v8 = 1'b1; d8 = 8'hA5; c8 = 3'd3;
    tick();
    v8 = 1'b0;
    frame8("t1", 8'hA5, 3'd3);

    // 2. Back-to-back with in_valid held; second accept exactly 10 edges later
    v8 = 1'b1; d8 = 8'hFF; c8 = 3'd7;
    tick();
    d8 = 8'h01; c8 = 3'd0;
    frame8("t2a", 8'hFF, 3'd7);
    tick();
    v8 = 1'b0;
    frame8("t2b", 8'h01, 3'd0);

    // 3. Request while busy is held off until IDLE
    v8 = 1'b1; d8 = 8'h81; c8 = 3'd2;
    tick();
    d8 = 8'h3C; c8 = 3'd5;
    frame8("t3a", 8'h81, 3'd2);
    tick();
    v8 = 1'b0;
    frame8("t3b", 8'h3C, 3'd5);

    // 4. Reset on the 4th bit of 0xF0 / channel 6
    v8 = 1'b1; d8 = 8'hF0; c8 = 3'd6;
    tick();
    v8 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t4_bit%0d", k), {31'd0, din8}, 32'd1);
      check($sformatf("t4_sel%0d", k), {29'd0, sel8}, 32'd6);
      if (k < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_din",  {31'd0, din8},  32'd0);
    check("t4_sel",  {29'd0, sel8},  32'd0);
    check("t4_busy", {31'd0, busy8}, 32'd0);
    check("t4_rdy",  {31'd0, rdy8},  32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t4_nodone%0d", k), {31'd0, done8}, 32'd0);
      check($sformatf("t4_lowdin%0d", k), {31'd0, din8},  32'd0);
    end

    // Reset wins over a simultaneous accept
    rst = 1'b1; v8 = 1'b1; d8 = 8'hFF; c8 = 3'd4;
    tick();
    rst = 1'b0; v8 = 1'b0;
    check("prio_busy", {31'd0, busy8}, 32'd0);
    check("prio_sel",  {29'd0, sel8},  32'd0);
    tick();
    check("prio_busy2", {31'd0, busy8}, 32'd0);
    check("prio_din2",  {31'd0, din8},  32'd0);

    // 5a. DATA_W=4, GAP=0: 0xB then an accept in cycle 5
    pat4 = 4'hB;
    v4 = 1'b1; d4 = 4'hB; c4 = 3'd1;
    tick();
    d4 = 4'h4; c4 = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t5a_bit%0d", k),  {31'd0, din4},  {31'd0, pat4[4-k]});
      check($sformatf("t5a_busy%0d", k), {31'd0, busy4}, 32'd1);
      check($sformatf("t5a_done%0d", k), {31'd0, done4}, 32'd0);
      check($sformatf("t5a_sel%0d", k),  {29'd0, sel4},  32'd1);
      tick();
    end
    check("t5a_c5_done", {31'd0, done4}, 32'd1);
    check("t5a_c5_busy", {31'd0, busy4}, 32'd0);
    check("t5a_c5_rdy",  {31'd0, rdy4},  32'd1);
    check("t5a_c5_din",  {31'd0, din4},  32'd0);
    tick();
    v4 = 1'b0;
    check("t5a_acc2_sel",  {29'd0, sel4},  32'd2);
    check("t5a_acc2_busy", {31'd0, busy4}, 32'd1);
    check("t5a_acc2_bit1", {31'd0, din4},  32'd0);
    tick();
    check("t5a_acc2_bit2", {31'd0, din4},  32'd1);
    for (int k = 0; k < 4; k++) tick();
    check("t5a_drain_busy", {31'd0, busy4}, 32'd0);

    // 5b. GAP=3: busy for 8+3 cycles, line low in the gap
    patg = 8'hC3;
    vg = 1'b1; dg = 8'hC3; cg = 3'd4;
    tick();
    vg = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) begin
        check($sformatf("t5b_bit%0d", k), {31'd0, ding}, {31'd0, patg[8-k]});
      end else begin
        check($sformatf("t5b_gapdin%0d", k), {31'd0, ding}, 32'd0);
      end
      check($sformatf("t5b_busy%0d", k), {31'd0, busyg}, 32'd1);
      check($sformatf("t5b_sel%0d", k),  {29'd0, selg},  32'd4);
      check($sformatf("t5b_done%0d", k), {31'd0, doneg}, (k == 9) ? 32'd1 : 32'd0);
      tick();
    end
    check("t5b_end_busy", {31'd0, busyg}, 32'd0);
    check("t5b_end_rdy",  {31'd0, rdyg},  32'd1);
    check("t5b_end_din",  {31'd0, ding},  32'd0);

    // 6. Integration: 0xAA to each of the 8 demux outputs
    tick();
    check("t6_idle_dmx", {24'd0, dmx}, 32'd0);
    for (int ch = 0; ch < 8; ch++) begin
      v8 = 1'b1; d8 = 8'hAA; c8 = 3'(ch);
      tick();
      v8 = 1'b0;
      one_hot = 8'h01 << ch;
      for (int k = 1; k <= 10; k++) begin
        exp_dmx = ((k <= 8) && (k % 2 == 1)) ? one_hot : 8'h00;
        check($sformatf("t6_ch%0d_c%0d", ch, k), {24'd0, dmx}, {24'd0, exp_dmx});
        if (k < 10) tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
